// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus timing stage: FSM encoding, command codes
// and the power-up init ROM.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_EN_HI,
    S_WAIT,
    S_IDLE
  } state_t;

  localparam int INIT_LEN = 6;
  localparam int LINE_LEN = 16;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_LINE0 = 8'h80;
  localparam logic [7:0] CMD_LINE1 = 8'hC0;

  // 8-bit bus, 2 lines, display on, entry mode increment
  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = 8'h38;
      3'd3:             init_rom = 8'h0C;
      3'd4:             init_rom = CMD_CLEAR;
      3'd5:             init_rom = 8'h06;
      default:          init_rom = 8'h00;
    endcase
  endfunction

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    is_long_cmd = !rs && (data == CMD_CLEAR || data == CMD_HOME);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; holds at zero and reports it. RST_VAL is the count
// loaded by reset so the first state's delay starts without an explicit load.
module lcd_delay_timer #(
  parameter int               CNT_W   = 21,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_bus_timing.sv
// HD44780-style 8-bit write bus driver with automatic power-up init.
// Optional line auto-wrap is enabled by defining LCD_AUTOWRAP_EN.
module lcd_bus_timing
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 5,
  parameter int EN_HIGH_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int PWRUP_WAIT_CYC = 2000000,
  parameter int CNT_W          = 21
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic       busy,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA
);

  state_t           state, state_next;
  logic [2:0]       init_idx;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_zero;
  logic             wait_long;
  logic             first_rs;
  logic [7:0]       first_data;
  logic             pend_valid;
  logic [7:0]       pend_data;

  lcd_delay_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(CNT_W'(PWRUP_WAIT_CYC - 1))
  ) u_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .load    (timer_load),
    .load_val(timer_val),
    .zero    (timer_zero)
  );

  // The first two 0x38 writes of the init need the long settle time as well
  assign wait_long = is_long_cmd(LCD_RS, LCD_DATA) || (!init_done && init_idx < 3'd2);

`ifdef LCD_AUTOWRAP_EN
  logic [5:0] column;   // characters written since clear/home/line-0 wrap, 0..32
  logic       insert;

  assign insert     = in_rs && (column == 6'(LINE_LEN) || column == 6'(2 * LINE_LEN));
  assign first_rs   = insert ? 1'b0 : in_rs;
  assign first_data = !insert ? in_data :
                      (column == 6'(2 * LINE_LEN)) ? CMD_LINE0 : CMD_LINE1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      column     <= '0;
      pend_valid <= 1'b0;
      pend_data  <= 8'h00;
    end else if (state == S_IDLE && in_valid) begin
      if (in_rs) begin
        column <= (column == 6'(2 * LINE_LEN)) ? 6'd1 : column + 6'd1;
      end else if (is_long_cmd(in_rs, in_data)) begin
        column <= '0;
      end
      if (insert) begin
        pend_valid <= 1'b1;
        pend_data  <= in_data;
      end
    end else if (state == S_WAIT && timer_zero) begin
      pend_valid <= 1'b0;
    end
  end
`else
  assign first_rs   = in_rs;
  assign first_data = in_data;
  assign pend_valid = 1'b0;
  assign pend_data  = 8'h00;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_PWRUP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state)
      S_PWRUP: if (timer_zero) begin
        state_next = S_SETUP;
        timer_load = 1'b1;
        timer_val  = CNT_W'(SETUP_CYC - 1);
      end
      S_SETUP: if (timer_zero) begin
        state_next = S_EN_HI;
        timer_load = 1'b1;
        timer_val  = CNT_W'(EN_HIGH_CYC - 1);
      end
      S_EN_HI: if (timer_zero) begin
        state_next = S_WAIT;
        timer_load = 1'b1;
        timer_val  = wait_long ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
      end
      S_WAIT: if (timer_zero) begin
        if ((!init_done && init_idx != 3'(INIT_LEN - 1)) || pend_valid) begin
          state_next = S_SETUP;
          timer_load = 1'b1;
          timer_val  = CNT_W'(SETUP_CYC - 1);
        end else begin
          state_next = S_IDLE;
        end
      end
      S_IDLE: if (in_valid) begin
        state_next = S_SETUP;
        timer_load = 1'b1;
        timer_val  = CNT_W'(SETUP_CYC - 1);
      end
      default: state_next = S_PWRUP;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      LCD_EN    <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_DATA  <= 8'h00;
      init_done <= 1'b0;
      init_idx  <= '0;
    end else begin
      LCD_EN <= (state_next == S_EN_HI);
      case (state)
        S_PWRUP: if (timer_zero) begin
          LCD_RS   <= 1'b0;
          LCD_DATA <= init_rom(3'd0);
          init_idx <= '0;
        end
        S_WAIT: if (timer_zero) begin
          if (!init_done) begin
            if (init_idx == 3'(INIT_LEN - 1)) begin
              init_done <= 1'b1;
            end else begin
              init_idx <= init_idx + 3'd1;
              LCD_RS   <= 1'b0;
              LCD_DATA <= init_rom(init_idx + 3'd1);
            end
          end else if (pend_valid) begin
            LCD_RS   <= 1'b1;
            LCD_DATA <= pend_data;
          end
        end
        S_IDLE: if (in_valid) begin
          LCD_RS   <= first_rs;
          LCD_DATA <= first_data;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign LCD_RW   = 1'b0;

endmodule
